// File: rtl/mac_frame_accum.sv
// Sums FRAME_LEN unsigned samples into one saturating frame total.
// Latency: the result is visible the cycle after the last sample is accepted.
// Backpressure: in_ready drops while a result waits for out_ready.
module mac_frame_accum #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sat_flag;

    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sat_sum;
    logic                 last;

    // One extra bit of headroom exposes the overflow directly as the carry.
    assign sum     = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, in_data};
    assign ovf     = sum[ACC_WIDTH];
    assign sat_sum = ovf ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    assign last    = (cnt == CNT_W'(FRAME_LEN - 1));

    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            // The last reported out_sum/out_sat are deliberately left intact.
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == ACCUM) begin
            if (in_valid) begin
                if (last) begin
                    out_sum   <= sat_sum;
                    out_sat   <= sat_flag | ovf;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sat_flag  <= 1'b0;
                    state     <= HOLD;
                end else begin
                    acc      <= sat_sum;
                    cnt      <= cnt + CNT_W'(1);
                    sat_flag <= sat_flag | ovf;
                end
            end
        end else begin
            // A sample offered on the handshake cycle is not taken.
            if (out_ready) begin
                out_valid <= 1'b0;
                state     <= ACCUM;
            end
        end
    end

endmodule
